// File: rtl/pwm_controller.sv
// pwm_controller: multi-channel PWM with shadowed duty registers, a start/stop/burst
// state machine and a small memory-mapped register port.
// Build option: define PWM_POLARITY_EN to add the per-channel output polarity
// register at address 7.
module pwm_controller #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CW     = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [CW-1:0]     tick,
  input  logic              bus_we,
  input  logic [2:0]        bus_addr,
  input  logic [CW-1:0]     bus_wdata,
  output logic [CW-1:0]     bus_rdata,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              period_done,
  output logic              busy
);

  localparam int unsigned AW     = 3;
  localparam logic [CW-1:0] TMAX = {CW{1'b1}};
  localparam logic [AW-1:0] A_CTRL = AW'(4);
  localparam logic [AW-1:0] A_BCNT = AW'(5);
  localparam logic [AW-1:0] A_STAT = AW'(6);
`ifdef PWM_POLARITY_EN
  localparam logic [AW-1:0] A_POL  = AW'(7);
`endif

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARMED    = 2'd1,
    ST_RUN      = 2'd2,
    ST_STOPPING = 2'd3
  } state_e;

  state_e                   state_q, state_d;
  logic [NUM_CH-1:0][CW-1:0] duty_q, duty_d;
  logic [NUM_CH-1:0][CW-1:0] act_q, act_d;
  logic                     en_q, en_d;
  logic                     burst_q, burst_d;
  logic [CW-1:0]            bcnt_q, bcnt_d;
  logic [CW-1:0]            brem_q, brem_d;
  logic [NUM_CH-1:0]        pwm_q, pwm_d;
  logic                     done_q, done_d;
  logic                     busy_q, busy_d;
`ifdef PWM_POLARITY_EN
  logic [NUM_CH-1:0]        pol_q, pol_d;
`endif

  logic                     boundary;
  logic                     wr_ctrl;
  logic                     wr_en_set;
  logic                     wr_en_clr;
  logic                     cmp_active;
  logic [NUM_CH-1:0]        cmp;

  // Period boundary and CTRL write decode
  assign boundary  = (tick == TMAX);
  assign wr_ctrl   = bus_we && (bus_addr == A_CTRL);
  assign wr_en_set = wr_ctrl && bus_wdata[0];
  assign wr_en_clr = wr_ctrl && !bus_wdata[0];

  // Plain register writes: shadow duties, burst count, polarity
  always_comb begin
    duty_d = duty_q;
    bcnt_d = bcnt_q;
`ifdef PWM_POLARITY_EN
    pol_d  = pol_q;
`endif
    if (bus_we) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (bus_addr == AW'(i)) duty_d[i] = bus_wdata;
      end
      if (bus_addr == A_BCNT) bcnt_d = bus_wdata;
`ifdef PWM_POLARITY_EN
      if (bus_addr == A_POL) pol_d = bus_wdata[NUM_CH-1:0];
`endif
    end
  end

  // Control state machine: arming, run, graceful stop and burst countdown
  always_comb begin
    state_d = state_q;
    act_d   = act_q;
    brem_d  = brem_q;
    en_d    = en_q;
    burst_d = burst_q;
    done_d  = 1'b0;

    if (wr_ctrl) begin
      en_d    = bus_wdata[0];
      burst_d = bus_wdata[1];
    end

    unique case (state_q)
      ST_IDLE: begin
        if (wr_en_set) state_d = ST_ARMED;
      end

      ST_ARMED: begin
        // Disable wins over a coincident boundary
        if (wr_en_clr) begin
          state_d = ST_IDLE;
        end else if (boundary) begin
          act_d   = duty_q;
          brem_d  = (bcnt_q == '0) ? CW'(1) : bcnt_q;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (boundary) begin
          done_d = 1'b1;
          act_d  = duty_q;
          if (burst_q && (brem_q == CW'(1))) begin
            // Burst completion retires the whole control word
            state_d = ST_IDLE;
            en_d    = 1'b0;
            burst_d = 1'b0;
          end else begin
            if (burst_q) brem_d = brem_q - CW'(1);
            if (wr_en_clr) state_d = ST_STOPPING;
          end
        end else if (wr_en_clr) begin
          state_d = ST_STOPPING;
        end
      end

      ST_STOPPING: begin
        // ACT stays frozen; re-enable resumes the same period in place
        if (boundary) done_d = 1'b1;
        if (wr_en_set) begin
          state_d = ST_RUN;
        end else if (boundary) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // Compare tick against active duty; optional polarity inversion
  always_comb begin
    cmp_active = (state_q == ST_RUN) || (state_q == ST_STOPPING);
    cmp        = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cmp[i] = cmp_active && (tick < act_q[i]);
    end
`ifdef PWM_POLARITY_EN
    pwm_d = cmp ^ pol_q;
`else
    pwm_d = cmp;
`endif
  end

  // Combinational register readback
  always_comb begin
    bus_rdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus_addr == AW'(i)) bus_rdata = duty_q[i];
    end
    case (bus_addr)
      A_CTRL:  bus_rdata = CW'({burst_q, en_q});
      A_BCNT:  bus_rdata = bcnt_q;
      A_STAT:  bus_rdata = CW'(state_q);
`ifdef PWM_POLARITY_EN
      A_POL:   bus_rdata = CW'(pol_q);
`endif
      default: ;
    endcase
  end

  // State, registers and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      duty_q  <= '0;
      act_q   <= '0;
      en_q    <= 1'b0;
      burst_q <= 1'b0;
      bcnt_q  <= '0;
      brem_q  <= '0;
      pwm_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef PWM_POLARITY_EN
      pol_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      act_q   <= act_d;
      en_q    <= en_d;
      burst_q <= burst_d;
      bcnt_q  <= bcnt_d;
      brem_q  <= brem_d;
      pwm_q   <= pwm_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
`ifdef PWM_POLARITY_EN
      pol_q   <= pol_d;
`endif
    end
  end

  assign pwm_out     = pwm_q;
  assign period_done = done_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_pwm_controller.sv
// tb_pwm_controller: directed checks of duty compare, shadow update, stop, burst,
// reset and (when PWM_POLARITY_EN is defined) polarity.
module tb_pwm_controller;

  logic       clk;
  logic       rst;
  logic [7:0] tick;
  logic       we;
  logic [2:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic [3:0] pwm;
  logic       pdone;
  logic       busy;

  int n_checks;
  int n_pass;
  int n_fail;

  pwm_controller #(.NUM_CH(4), .CW(8)) dut (
    .clock      (clk),
    .reset      (rst),
    .tick       (tick),
    .bus_we     (we),
    .bus_addr   (addr),
    .bus_wdata  (wdata),
    .bus_rdata  (rdata),
    .pwm_out    (pwm),
    .period_done(pdone),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: sample after the edge, then advance the free-running tick
  task automatic cyc();
    @(posedge clk);
    #1;
    tick = tick + 8'd1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    we = 1'b1; addr = a; wdata = d;
    cyc();
    we = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [2:0] a, input logic [7:0] exp);
    addr = a;
    #1;
    check(tag, 32'(rdata), 32'(exp));
  endtask

  // Run until the next edge will sample tick == v, counting pwm_out[0] highs
  task automatic wait_tick(input logic [7:0] v, output int hi);
    int n;
    n = 0; hi = 0;
    while (tick != v && n < 400) begin
      cyc();
      n++;
      if (pwm[0]) hi++;
    end
    if (tick != v) begin
      n_checks++; n_fail++;
      $error("FAIL wait_tick: tick %0d expected %0d", tick, v);
    end
  endtask

  // One full period (edges at tick 0..255), optional single write at tick wr_at
  task automatic measure(input int wr_at, input logic [2:0] wa, input logic [7:0] wd,
                         output int hi0, output int hi1, output int dn);
    hi0 = 0; hi1 = 0; dn = 0;
    for (int k = 0; k < 256; k++) begin
      if (int'(tick) == wr_at) begin
        we = 1'b1; addr = wa; wdata = wd;
      end
      cyc();
      we = 1'b0;
      if (pwm[0]) hi0++;
      if (pwm[1]) hi1++;
      if (pdone)  dn++;
    end
  endtask

  initial begin
    int hi0, hi1, dn, hw, s_hi, s_dn;
    n_checks = 0; n_pass = 0; n_fail = 0;
    rst = 1'b1; tick = 8'd0; we = 1'b0; addr = 3'd0; wdata = 8'd0;

    // Reset state
    cyc();
    check("rst_pwm", 32'(pwm), 0);
    check("rst_done", 32'(pdone), 0);
    check("rst_busy", 32'(busy), 0);
    rd("rst_duty0", 3'd0, 8'd0);
    rd("rst_ctrl", 3'd4, 8'd0);
    rd("rst_status", 3'd6, 8'd0);
    cyc();
    rst = 1'b0;
    tick = 8'd10;

    // Continuous duty 64
    wr(3'd0, 8'd64);
    rd("duty0_rb", 3'd0, 8'd64);
    wr(3'd4, 8'd1);
    check("armed_busy", 32'(busy), 1);
    rd("armed_status", 3'd6, 8'd1);
    wait_tick(8'd255, hw);
    check("armed_low", 32'(hw), 0);
    cyc();
    rd("run_status", 3'd6, 8'd2);
    measure(-1, 3'd0, 8'd0, hi0, hi1, dn);
    check("cont1_hi", 32'(hi0), 64);
    check("cont1_ch1", 32'(hi1), 0);
    check("cont1_done", 32'(dn), 1);
    measure(-1, 3'd0, 8'd0, hi0, hi1, dn);
    check("cont2_hi", 32'(hi0), 64);
    check("cont2_done", 32'(dn), 1);

    // Shadow update mid-period, then on the boundary edge itself
    measure(100, 3'd0, 8'd128, hi0, hi1, dn);
    check("shadow_cur", 32'(hi0), 64);
    measure(-1, 3'd0, 8'd0, hi0, hi1, dn);
    check("shadow_next", 32'(hi0), 128);
    measure(255, 3'd0, 8'd32, hi0, hi1, dn);
    check("bnd_cur", 32'(hi0), 128);
    measure(-1, 3'd0, 8'd0, hi0, hi1, dn);
    check("bnd_next", 32'(hi0), 128);
    measure(-1, 3'd0, 8'd0, hi0, hi1, dn);
    check("bnd_later", 32'(hi0), 32);

    // Graceful stop at tick 100
    measure(100, 3'd4, 8'd0, hi0, hi1, dn);
    check("stop_hi", 32'(hi0), 32);
    check("stop_done", 32'(dn), 1);
    check("stop_busy", 32'(busy), 0);
    rd("stop_status", 3'd6, 8'd0);
    measure(-1, 3'd0, 8'd0, hi0, hi1, dn);
    check("idle_hi", 32'(hi0), 0);
    check("idle_done", 32'(dn), 0);

    // Stop then resume within the same period
    wr(3'd4, 8'd1);
    wait_tick(8'd255, hw);
    cyc();
    wait_tick(8'd50, hw);
    check("resume_pre_hi", 32'(hw), 32);
    wr(3'd4, 8'd0);
    rd("stopping_status", 3'd6, 8'd3);
    check("stopping_busy", 32'(busy), 1);
    wait_tick(8'd150, hw);
    wr(3'd4, 8'd1);
    rd("resumed_status", 3'd6, 8'd2);
    wait_tick(8'd255, hw);
    cyc();
    check("resume_done", 32'(pdone), 1);
    measure(-1, 3'd0, 8'd0, hi0, hi1, dn);
    check("resume_hi", 32'(hi0), 32);
    check("resume_busy", 32'(busy), 1);

    // Burst of 3
    wr(3'd4, 8'd0);
    wait_tick(8'd255, hw);
    cyc();
    check("pre_burst_busy", 32'(busy), 0);
    wr(3'd5, 8'd3);
    wr(3'd4, 8'd3);
    wait_tick(8'd255, hw);
    cyc();
    s_hi = 0; s_dn = 0;
    for (int p = 0; p < 3; p++) begin
      measure(-1, 3'd0, 8'd0, hi0, hi1, dn);
      s_hi += hi0; s_dn += dn;
    end
    check("burst3_hi", 32'(s_hi), 96);
    check("burst3_done", 32'(s_dn), 3);
    check("burst3_busy", 32'(busy), 0);
    rd("burst3_ctrl", 3'd4, 8'd0);
    rd("burst3_status", 3'd6, 8'd0);
    measure(-1, 3'd0, 8'd0, hi0, hi1, dn);
    check("burst3_after_hi", 32'(hi0), 0);
    check("burst3_after_done", 32'(dn), 0);

    // Burst count 0 behaves as 1
    wr(3'd5, 8'd0);
    wr(3'd4, 8'd3);
    wait_tick(8'd255, hw);
    cyc();
    measure(-1, 3'd0, 8'd0, hi0, hi1, dn);
    check("burst0_hi", 32'(hi0), 32);
    check("burst0_done", 32'(dn), 1);
    check("burst0_busy", 32'(busy), 0);
    measure(-1, 3'd0, 8'd0, hi0, hi1, dn);
    check("burst0_after_hi", 32'(hi0), 0);

    // Reset mid-period with output high
    wr(3'd0, 8'd64);
    wr(3'd4, 8'd1);
    wait_tick(8'd255, hw);
    cyc();
    wait_tick(8'd50, hw);
    check("premrst_hi", 32'(hw), 50);
    check("premrst_pwm", 32'(pwm[0]), 1);
    rst = 1'b1;
    #1;
    check("mrst_pwm", 32'(pwm), 0);
    check("mrst_busy", 32'(busy), 0);
    check("mrst_done", 32'(pdone), 0);
    rd("mrst_duty0", 3'd0, 8'd0);
    cyc();
    rst = 1'b0;
    rd("mrst_status", 3'd6, 8'd0);
    wr(3'd0, 8'd64);
    wr(3'd4, 8'd1);
    check("rearm_busy", 32'(busy), 1);
    wait_tick(8'd255, hw);
    check("rearm_wait_low", 32'(hw), 0);
    cyc();
    measure(-1, 3'd0, 8'd0, hi0, hi1, dn);
    check("rearm_hi", 32'(hi0), 64);
    check("rearm_done", 32'(dn), 1);

`ifdef PWM_POLARITY_EN
    // Polarity: idle level and inverted duty
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    wr(3'd7, 8'd1);
    cyc();
    check("pol_idle_pwm", 32'(pwm[0]), 1);
    rd("pol_rb", 3'd7, 8'd1);
    wr(3'd0, 8'd32);
    wr(3'd4, 8'd1);
    wait_tick(8'd255, hw);
    cyc();
    measure(-1, 3'd0, 8'd0, hi0, hi1, dn);
    check("pol_hi", 32'(hi0), 224);
    check("pol_ch1", 32'(hi1), 0);
`else
    // Address 7 is inert without the polarity option
    wr(3'd7, 8'hFF);
    rd("addr7_rb", 3'd7, 8'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
